// File: rtl/bus_mem_responder_if.sv
// Bus between a fetch/memory initiator and the memory responder.
//   master : initiator side (drives request beats, consumes response beats)
//   slave  : responder side (acks request beats, drives response beats)
// Signals:
//   bus_reqcyc/bus_req/bus_reqtag : request beat valid, address/data, tag
//   bus_reqack                    : one-cycle accept pulse per request beat
//   bus_respcyc/bus_resp/bus_resptag : response beat valid, data, echoed tag
//   bus_respack                   : initiator consumed the current response beat
interface bus_mem_responder_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
);
  logic                      bus_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_req;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
  logic                      bus_reqack;
  logic                      bus_respcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_resp;
  logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
  logic                      bus_respack;

  modport master (
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
  );

  modport slave (
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag
  );
endinterface

// File: rtl/bus_mem_responder.sv
// Memory-side responder of the system bus. Accepts block write/read requests
// (address beat + tag), stores 64-bit words in an internal array and returns
// BEATS-beat block reads after LATENCY idle cycles.
// Ports:
//   clk   : clock, all state changes on posedge
//   reset : synchronous active-high reset (memory array is not cleared)
//   bus   : bus_mem_responder_if.slave (request/ack, response/ack)
// Optional feature macro RESP_CRITICAL_WORD_FIRST_EN: read bursts start at the
// requested word and wrap within the block; otherwise they start at word 0.
module bus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 4096,
  parameter int BEATS          = 8,
  parameter int LATENCY        = 4
) (
  input logic clk,
  input logic reset,
  bus_mem_responder_if.slave bus
);
  localparam int BYTE_SH = $clog2(BUS_DATA_WIDTH / 8);
  localparam int AW      = $clog2(MEM_WORDS);
  localparam int BW      = $clog2(BEATS);
  localparam int LW      = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, WDATA, WAIT, RESP} state_t;

  state_t                    state;
  logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [AW-1:0]             base;
  logic [BW-1:0]             beat;
  logic [LW-1:0]             lat_cnt;
  logic [BUS_TAG_WIDTH-1:0]  tag;
`ifdef RESP_CRITICAL_WORD_FIRST_EN
  logic [BW-1:0]             first;
`endif

  logic [AW-1:0] req_word;
  logic          accept;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [BW-1:0] nxt_beat;
  logic [AW-1:0] rd_addr;

  // Address bits above the array are dropped, so addresses alias modulo MEM_WORDS.
  assign req_word = bus.bus_req[BYTE_SH +: AW];
  // A beat is taken only when the previous ack has completed: min 2 cycles/beat.
  assign accept   = bus.bus_reqcyc && !bus.bus_reqack && (state == IDLE || state == WDATA);
  assign wr_en    = accept && (state == WDATA);
  assign wr_addr  = base | AW'(beat);

  // Word to present next: beat 0 when leaving WAIT, beat+1 on a RESP ack.
  always_comb begin
    nxt_beat = (state == RESP) ? beat + BW'(1) : '0;
`ifdef RESP_CRITICAL_WORD_FIRST_EN
    rd_addr  = base | AW'(BW'(first + nxt_beat));
`else
    rd_addr  = base | AW'(nxt_beat);
`endif
  end

  // Memory is kept across reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem[wr_addr] <= bus.bus_req;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      base            <= '0;
      beat            <= '0;
      lat_cnt         <= '0;
      tag             <= '0;
`ifdef RESP_CRITICAL_WORD_FIRST_EN
      first           <= '0;
`endif
      bus.bus_reqack  <= 1'b0;
      bus.bus_respcyc <= 1'b0;
      bus.bus_resp    <= '0;
      bus.bus_resptag <= '0;
    end else begin
      bus.bus_reqack <= accept;
      case (state)
        IDLE: if (accept) begin
          base <= {req_word[AW-1:BW], BW'(0)};
          tag  <= bus.bus_reqtag;
          beat <= '0;
`ifdef RESP_CRITICAL_WORD_FIRST_EN
          first <= req_word[BW-1:0];
`endif
          if (bus.bus_reqtag[BUS_TAG_WIDTH-1]) begin
            state <= WDATA;
          end else begin
            state   <= WAIT;
            lat_cnt <= LW'(LATENCY);
          end
        end
        WDATA: if (accept) begin
          beat <= beat + BW'(1);
          if (beat == LAST) state <= IDLE;
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            state           <= RESP;
            bus.bus_respcyc <= 1'b1;
            bus.bus_resp    <= mem[rd_addr];
            bus.bus_resptag <= tag;
          end else begin
            lat_cnt <= lat_cnt - LW'(1);
          end
        end
        RESP: if (bus.bus_respack) begin
          if (beat == LAST) begin
            bus.bus_respcyc <= 1'b0;
            beat            <= '0;
            state           <= IDLE;
          end else begin
            beat         <= nxt_beat;
            bus.bus_resp <= mem[rd_addr];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_mem_responder.sv
// Scoreboard bench for bus_mem_responder: stimulus pushes expected read beats
// computed from a flat reference memory; a negedge monitor pops and compares
// every consumed response beat and checks beats hold while not acked.
module tb_bus_mem_responder;
  localparam int DW  = 64;
  localparam int TW  = 13;
  localparam int MW  = 4096;
  localparam int NB  = 8;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_mem_responder_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) bus ();

  bus_mem_responder #(
    .BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .MEM_WORDS(MW), .BEATS(NB), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [TW-1:0] t;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] ref_mem [MW];
  logic [63:0] blk [NB];
  int checks = 0, fails = 0;
  int beats_got = 0, acks = 0, acks_exp = 0;
  int ack_mode = 0;
  bit drv_en = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    fails++;
    $display("FAIL %s: timed out", name);
  endtask

  // respack driver: 0 = held high, 1 = pattern 1,0,0, 2 = random
  int tog = 0;
  always @(posedge clk) begin
    #1;
    if (drv_en) begin
      case (ack_mode)
        0: bus.bus_respack = 1'b1;
        1: begin bus.bus_respack = (tog == 0); tog = (tog + 1) % 3; end
        default: bus.bus_respack = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor
  logic        prev_v = 1'b0;
  logic [63:0] prev_d;
  logic [12:0] prev_t;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (bus.bus_reqack) acks++;
      if (bus.bus_respcyc) begin
        if (prev_v) begin
          chk("held resp", bus.bus_resp, prev_d);
          chk("held resptag", 64'(bus.bus_resptag), 64'(prev_t));
        end
        if (bus.bus_respack) begin
          prev_v = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL extra beat: got %h expected none", bus.bus_resp);
          end else begin
            e = exp_q.pop_front();
            chk("resp data", bus.bus_resp, e.d);
            chk("resptag", 64'(bus.bus_resptag), 64'(e.t));
            beats_got++;
          end
        end else begin
          prev_v = 1'b1;
          prev_d = bus.bus_resp;
          prev_t = bus.bus_resptag;
        end
      end else begin
        prev_v = 1'b0;
      end
    end
  end

  // Drive one request beat (call at posedge+1); returns at the negedge the ack is seen.
  task automatic send_beat(input logic [63:0] d, input logic [12:0] t);
    int n;
    n = 0;
    bus.bus_reqcyc = 1'b1;
    bus.bus_req    = d;
    bus.bus_reqtag = t;
    acks_exp++;
    do begin @(negedge clk); n++; end while (!bus.bus_reqack && n < 50);
    if (!bus.bus_reqack) timeout_fail("reqack");
  endtask

  function automatic int word_of(input logic [63:0] addr);
    return int'((addr / 8) % MW);
  endfunction

  task automatic do_write(input logic [63:0] addr, input logic [11:0] tl);
    int base;
    base = word_of(addr) - word_of(addr) % NB;
    send_beat(addr, {1'b1, tl});
    for (int i = 0; i < NB; i++) begin
      @(posedge clk); #1;
      send_beat(blk[i], 13'($urandom));
      chk("respcyc during write", 64'(bus.bus_respcyc), 64'd0);
      ref_mem[base + i] = blk[i];
    end
    @(posedge clk); #1;
    bus.bus_reqcyc = 1'b0;
  endtask

  // Expected beats for a read of addr: critical-word-first order when enabled.
  task automatic push_read(input logic [63:0] addr, input logic [11:0] tl);
    int w, base, off;
    exp_t e;
    w    = word_of(addr);
    base = w - w % NB;
`ifdef RESP_CRITICAL_WORD_FIRST_EN
    off  = w % NB;
`else
    off  = 0;
`endif
    for (int i = 0; i < NB; i++) begin
      e.d = ref_mem[base + (off + i) % NB];
      e.t = {1'b0, tl};
      exp_q.push_back(e);
    end
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [11:0] tl, input bit noise);
    int n;
    push_read(addr, tl);
    beats_got = 0;
    send_beat(addr, {1'b0, tl});
    @(posedge clk); #1;
    if (noise) begin
      // Requests during WAIT/RESP must be ignored.
      bus.bus_reqcyc = 1'b1;
      bus.bus_reqtag = 13'h1000;
      bus.bus_req    = {$urandom, $urandom};
    end else begin
      bus.bus_reqcyc = 1'b0;
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.bus_respcyc && n < 100);
    chk("first beat latency", 64'(n), 64'(LAT + 1));
    n = 0;
    while (exp_q.size() > 0 && n < 300) begin @(negedge clk); #1; n++; end
    bus.bus_reqcyc = 1'b0;
    if (exp_q.size() != 0) begin
      timeout_fail("read burst");
      exp_q.delete();
    end
    @(negedge clk);
    chk("respcyc after last beat", 64'(bus.bus_respcyc), 64'd0);
    chk("beat count", 64'(beats_got), 64'(NB));
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, blocks[8];
    logic [63:0] a;
    for (int i = 0; i < MW; i++) ref_mem[i] = '0;
    reset = 1'b1;
    bus.bus_reqcyc = 1'b0; bus.bus_req = '0; bus.bus_reqtag = '0; bus.bus_respack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset reqack", 64'(bus.bus_reqack), 64'd0);
    chk("reset respcyc", 64'(bus.bus_respcyc), 64'd0);
    chk("reset resp", bus.bus_resp, 64'd0);
    chk("reset resptag", 64'(bus.bus_resptag), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed write of 0x1111..0x8888 to block at 0x40, then reads.
    for (int i = 0; i < NB; i++) blk[i] = 64'h1111 * (i + 1);
    do_write(64'h40, 12'h000);
    ack_mode = 0; do_read(64'h40, 12'h005, 1'b0);
    ack_mode = 1; do_read(64'h40, 12'h005, 1'b1);
    ack_mode = 0; do_read(64'h58, 12'h007, 1'b0);
    ack_mode = 2; do_read(64'h8040, 12'h009, 1'b0);

    // Reset in the middle of a read burst.
    ack_mode = 0;
    @(posedge clk); #1;
    push_read(64'h40, 12'h005);
    beats_got = 0;
    send_beat(64'h40, 13'h0005);
    @(posedge clk); #1;
    bus.bus_reqcyc = 1'b0;
    n = 0;
    while (beats_got < 3 && n < 100) begin @(negedge clk); #1; n++; end
    if (beats_got < 3) timeout_fail("pre-reset beats");
    drv_en = 1'b0;
    @(posedge clk); #1;
    bus.bus_respack = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("respcyc after reset", 64'(bus.bus_respcyc), 64'd0);
    chk("resp after reset", bus.bus_resp, 64'd0);
    reset = 1'b0;
    exp_q.delete();
    drv_en = 1'b1;
    @(posedge clk); #1;
    do_read(64'h40, 12'h00a, 1'b0);

    // Random phase over a small set of blocks, with high address bits randomized.
    for (int b = 0; b < 8; b++) begin
      blocks[b] = 8 * (2 + 37 * b);
      for (int i = 0; i < NB; i++) blk[i] = {$urandom, $urandom};
      a = {$urandom, $urandom};
      a[14:3] = 12'(blocks[b]);
      do_write(a, 12'($urandom));
    end
    for (int k = 0; k < 120; k++) begin
      a = {$urandom, $urandom};
      a[14:3] = 12'(blocks[$urandom_range(0, 7)] + $urandom_range(0, 7));
      ack_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < NB; i++) blk[i] = {$urandom, $urandom};
        do_write(a, 12'($urandom));
      end else begin
        do_read(a, 12'($urandom), 1'($urandom_range(0, 1)));
        @(posedge clk); #1;
      end
    end

    repeat (4) @(posedge clk);
    #1;
    chk("total reqack count", 64'(acks), 64'(acks_exp));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
